// File: rtl/param_acc_cpu.sv
// -----------------------------------------------------------------------------
// param_acc_cpu
//
// Parametrised accumulator CPU core: PC, IR, AC and a Z flag sequenced by a
// fetch/decode/execute FSM. Program and data share one memory that is reached
// through a req/ack handshake, so the memory may insert any number of wait
// states. Execution begins at address 0 when start is seen high in IDLE and
// stops in HALT. Leaving HALT requires start to go low, and a new run then
// needs start high again.
//
// Memory handshake (applies to every request):
//   mem_req is high for as long as the FSM sits in FETCH, MEMRD or MEMWR.
//   mem_we, mem_addr and mem_wdata come from registered state only, so they
//   hold steady from the first request cycle through the ack cycle.
//   mem_ack is a one-cycle strobe. It completes the request at the rising
//   edge where it is sampled high, and mem_rdata is taken in that same cycle.
//   An ack that arrives while mem_req is low is ignored. There is no timeout.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   start                level; memory loaded, begin execution at address 0
//   mem_req/mem_we       memory request and direction (1 = write)
//   mem_addr/mem_wdata   request address and write data (AC)
//   mem_rdata/mem_ack    read data and completion strobe
//   halted               high in HALT
//   pc_out/ac_out/z_flag architectural state
//   dbgState             current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module param_acc_cpu #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int OPC_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] ac_out,
   output logic              z_flag,
   output logic [2:0]        dbgState
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      MEMRD  = 3'd3,
      MEMWR  = 3'd4,
      HALT   = 3'd5
   } cpuState_t;

   localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_LDA  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_STA  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_INC  = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_CLR  = OPC_W'(9);
   localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(15);

   cpuState_t         state, stateNext;
   logic [ADDR_W-1:0] pc, pcNext;
   logic [DATA_W-1:0] ir, irNext;
   logic [DATA_W-1:0] ac, acNext;
   logic              z, zNext;

   logic [OPC_W-1:0]  opcode;
   logic [ADDR_W-1:0] opAddr;
   logic [DATA_W-1:0] aluResult;
   logic [DATA_W-1:0] incResult;

   assign opcode    = ir[DATA_W-1 -: OPC_W];
   assign opAddr    = ir[ADDR_W-1:0];
   assign incResult = ac + DATA_W'(1);

   // Memory-operand ALU. It is only consumed in MEMRD, where the opcode is
   // one of LDA/ADD/SUB/AND.
   always_comb begin
      aluResult = mem_rdata;
      case (opcode)
         OP_LDA:  aluResult = mem_rdata;
         OP_ADD:  aluResult = ac + mem_rdata;
         OP_SUB:  aluResult = ac - mem_rdata;
         OP_AND:  aluResult = ac & mem_rdata;
         default: aluResult = mem_rdata;
      endcase
   end

   // State and architectural registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= '0;
         ir    <= '0;
         ac    <= '0;
         z     <= 1'b0;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
         ir    <= irNext;
         ac    <= acNext;
         z     <= zNext;
      end
   end

   // Next-state, datapath updates and bus outputs.
   always_comb begin
      stateNext = state;
      pcNext    = pc;
      irNext    = ir;
      acNext    = ac;
      zNext     = z;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = ac;
      halted    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               pcNext    = '0;
               stateNext = FETCH;
            end
         end

         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               irNext    = mem_rdata;
               pcNext    = pc + ADDR_W'(1);
               stateNext = DECODE;
            end
         end

         DECODE: begin
            // Register-only instructions finish here. Everything else either
            // moves on to a memory state or stops.
            stateNext = FETCH;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_AND: stateNext = MEMRD;
               OP_STA:  stateNext = MEMWR;
               OP_JMP:  pcNext = opAddr;
               OP_JZ: begin
                  if (z) pcNext = opAddr;
               end
               OP_INC: begin
                  acNext = incResult;
                  zNext  = (incResult == '0);
               end
               OP_CLR: begin
                  acNext = '0;
                  zNext  = 1'b1;
               end
               OP_HALT: stateNext = HALT;
               OP_NOP:  stateNext = FETCH;
               default: stateNext = FETCH;  // unassigned opcodes behave as NOP
            endcase
         end

         MEMRD: begin
            mem_req  = 1'b1;
            mem_addr = opAddr;
            if (mem_ack) begin
               acNext    = aluResult;
               zNext     = (aluResult == '0);
               stateNext = FETCH;
            end
         end

         MEMWR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = opAddr;
            if (mem_ack) stateNext = FETCH;
         end

         HALT: begin
            halted = 1'b1;
            if (!start) stateNext = IDLE;
         end

         default: stateNext = IDLE;
      endcase
   end

   assign pc_out   = pc;
   assign ac_out   = ac;
   assign z_flag   = z;
   assign dbgState = state;

endmodule

// File: tb/tb_param_acc_cpu.sv
// -----------------------------------------------------------------------------
// tb_param_acc_cpu
//
// Bench for param_acc_cpu. It uses two instances:
//   u_dut  16/12 default widths, with a memory responder that can add random
//          or fixed wait states. An instruction-level reference model works
//          out the expected bus transactions (kept in exp_q), the final
//          PC/AC/Z and the cycle count from the instruction set rules.
//   u_dut2 24/16 widths, with a zero-wait responder and directed checks.
// -----------------------------------------------------------------------------
module tb_param_acc_cpu;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mem_req, mem_we, mem_ack, halted, z_flag;
   logic [11:0] mem_addr, pc_out;
   logic [15:0] mem_wdata, mem_rdata, ac_out;
   logic [2:0]  dbg1;

   logic        rst2_n, start2, req2, we2, ack2, halted2, z2;
   logic [15:0] addr2, pc2;
   logic [23:0] wdata2, rdata2, ac2;
   logic [2:0]  dbg2;

   param_acc_cpu u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .halted(halted), .pc_out(pc_out), .ac_out(ac_out), .z_flag(z_flag),
      .dbgState(dbg1)
   );

   param_acc_cpu #(.DATA_W(24), .ADDR_W(16), .OPC_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .start(start2),
      .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
      .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ack(ack2),
      .halted(halted2), .pc_out(pc2), .ac_out(ac2), .z_flag(z2),
      .dbgState(dbg2)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int nTests = 0;
   int nFail  = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // ---------------- memories and model ----------------
   logic [15:0] mem      [4096];
   logic [15:0] modelMem [4096];
   logic [23:0] mem2     [65536];

   logic [28:0] exp_q[$];   // {we, addr, wdata}
   logic [15:0] acM;
   logic        zM;
   logic [11:0] expPc;
   int          expCyc;

   // Instruction-level interpreter. Each fetch costs 2 cycles, and a memory
   // operand adds 1 more.
   task automatic runModel();
      logic [11:0] pc, a;
      logic [15:0] ir, opnd;
      logic [3:0]  op;
      int          steps;
      for (int i = 0; i < 4096; i++) modelMem[i] = mem[i];
      exp_q.delete();
      pc = 12'd0;
      expCyc = 0;
      steps = 0;
      while (steps < 2000) begin
         steps++;
         ir = modelMem[pc];
         exp_q.push_back({1'b0, pc, 16'h0000});
         pc = pc + 12'd1;
         expCyc += 2;
         op = ir[15:12];
         a  = ir[11:0];
         if (op == 4'd15) break;
         case (op)
            4'd1, 4'd3, 4'd4, 4'd5: begin
               exp_q.push_back({1'b0, a, 16'h0000});
               expCyc += 1;
               opnd = modelMem[a];
               if (op == 4'd1) acM = opnd;
               else if (op == 4'd3) acM = acM + opnd;
               else if (op == 4'd4) acM = acM - opnd;
               else acM = acM & opnd;
               zM = (acM == 16'h0000);
            end
            4'd2: begin
               exp_q.push_back({1'b1, a, acM});
               expCyc += 1;
               modelMem[a] = acM;
            end
            4'd6: pc = a;
            4'd7: if (zM) pc = a;
            4'd8: begin
               acM = acM + 16'd1;
               zM = (acM == 16'h0000);
            end
            4'd9: begin
               acM = 16'h0000;
               zM = 1'b1;
            end
            default: ;
         endcase
      end
      expPc = pc;
   endtask

   // ---------------- memory responder / bus compare (instance 1) ----------------
   bit          respEn = 0;
   bit          forceAck = 0;
   bit          counting = 0;
   int          waitMode = 0;    // <0: random 0..3 per request
   int          waitTotal = 0;
   int          cycCnt = 0;
   bit          pending = 0;
   int          waitLeft = 0;
   logic [11:0] holdAddr;
   logic        holdWe;
   logic [15:0] holdWdata;
   logic [28:0] e;

   initial begin
      mem_ack = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (counting && !halted) cycCnt++;
         if (!mem_req) pending = 0;
         if (forceAck) begin
            mem_ack = 1'b1;
         end else if (respEn && mem_req) begin
            if (!pending) begin
               pending   = 1;
               holdAddr  = mem_addr;
               holdWe    = mem_we;
               holdWdata = mem_wdata;
               waitLeft  = (waitMode < 0) ? int'($urandom_range(0, 3)) : waitMode;
               waitTotal += waitLeft;
            end else begin
               chk("hold_addr", mem_addr, holdAddr);
               chk("hold_we", mem_we, holdWe);
               if (holdWe) chk("hold_wdata", mem_wdata, holdWdata);
            end
            if (waitLeft == 0) begin
               mem_ack = 1'b1;
               pending = 0;
               if (exp_q.size() == 0) begin
                  chk("bus_unexpected_req", 0, 1);
               end else begin
                  e = exp_q.pop_front();
                  chk("bus_we", mem_we, e[28]);
                  chk("bus_addr", mem_addr, e[27:16]);
                  if (e[28]) chk("bus_wdata", mem_wdata, e[15:0]);
               end
               if (mem_we) mem[mem_addr] = mem_wdata;
               else mem_rdata = mem[mem_addr];
            end else begin
               waitLeft--;
            end
         end
      end
   end

   // ---------------- zero-wait responder (instance 2) ----------------
   initial begin
      ack2 = 1'b0;
      rdata2 = 24'h0;
      forever begin
         @(negedge clk);
         ack2 = 1'b0;
         if (req2) begin
            ack2 = 1'b1;
            if (!we2) rdata2 = mem2[addr2];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clearMem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   // Run whatever program is in mem from address 0, then compare the DUT's
   // final state and cycle count with the model.
   task automatic runProgram(input int wm, input string tag);
      bit ok;
      runModel();
      waitMode = wm;
      waitTotal = 0;
      cycCnt = 0;
      respEn = 1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      counting = 1;
      ok = 0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (halted) begin
            ok = 1;
            break;
         end
      end
      counting = 0;
      chk({tag, "_halted"}, ok, 1);
      chk({tag, "_bus_drained"}, exp_q.size(), 0);
      chk({tag, "_pc"}, pc_out, expPc);
      chk({tag, "_ac"}, ac_out, acM);
      chk({tag, "_z"}, z_flag, zM);
      chk({tag, "_cycles"}, cycCnt, expCyc + waitTotal);
   endtask

   task automatic waitFetch2(input logic [15:0] a, output bit ok);
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (req2 && !we2 && addr2 == a) begin
            ok = 1;
            break;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      rst_n = 1'b0;
      start = 1'b0;
      rst2_n = 1'b0;
      start2 = 1'b0;
      acM = 16'h0000;
      zM = 1'b0;
      clearMem();
      for (int i = 0; i < 65536; i++) mem2[i] = 24'h0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req", mem_req, 0);
      chk("rst_halted", halted, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_ac", ac_out, 0);
      chk("rst_z", z_flag, 0);

      // Reset in the middle of a fetch; a late ack must be ignored
      rst_n = 1'b1;
      start = 1'b1;
      ok = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mem_req) begin
            ok = 1;
            break;
         end
      end
      chk("t1_fetch_seen", ok, 1);
      chk("t1_fetch_addr", mem_addr, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t1_req_dropped", mem_req, 0);
      chk("t1_pc", pc_out, 0);
      chk("t1_ac", ac_out, 0);
      start = 1'b0;
      rst_n = 1'b1;
      forceAck = 1;
      repeat (2) @(negedge clk);
      forceAck = 0;
      repeat (3) @(negedge clk);
      chk("t1_stray_ack_req", mem_req, 0);
      chk("t1_stray_ack_pc", pc_out, 0);
      chk("t1_stray_ack_halted", halted, 0);

      // LDA/ADD/STA/HALT with zero-wait memory
      clearMem();
      mem[0] = 16'h100A; mem[1] = 16'h300B; mem[2] = 16'h200C; mem[3] = 16'hF000;
      mem[10] = 16'h7FFF; mem[11] = 16'h0001;
      runProgram(0, "t2");
      chk("t2_m12", mem[12], 16'h8000);
      chk("t2_z_lit", z_flag, 0);
      chk("t2_pc_lit", pc_out, 4);
      chk("t2_cycles_lit", cycCnt, 11);

      // Holding start high in HALT keeps the core halted
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t6_stay_halted", halted, 1);
         chk("t6_no_req", mem_req, 0);
      end
      // Restart: AC survives from the previous run
      clearMem();
      mem[0] = 16'h8000; mem[1] = 16'hF000;
      runProgram(0, "t6");
      chk("t6_ac_lit", ac_out, 16'h8001);
      chk("t6_pc_lit", pc_out, 2);

      // Same program with 3 wait states on every request
      clearMem();
      mem[0] = 16'h100A; mem[1] = 16'h300B; mem[2] = 16'h200C; mem[3] = 16'hF000;
      mem[10] = 16'h7FFF; mem[11] = 16'h0001;
      runProgram(3, "t4");
      chk("t4_m12", mem[12], 16'h8000);
      chk("t4_pc_lit", pc_out, 4);
      chk("t4_cycles_lit", cycCnt, 11 + 7 * 3);

      // AC wraps to zero, then JZ is taken
      clearMem();
      mem[0] = 16'h100A; mem[1] = 16'h8000; mem[2] = 16'h7005; mem[3] = 16'hF000;
      mem[5] = 16'hF000; mem[10] = 16'hFFFF;
      runProgram(0, "t3");
      chk("t3_ac_lit", ac_out, 16'h0000);
      chk("t3_z_lit", z_flag, 1);
      chk("t3_pc_lit", pc_out, 6);

      // Random forward-only programs with random wait states
      for (int p = 0; p < 25; p++) begin
         int n;
         int op;
         int tgt;
         clearMem();
         n = int'($urandom_range(4, 16));
         for (int i = 0; i < n - 1; i++) begin
            op = int'($urandom_range(0, 14));
            if (op == 6 || op == 7) tgt = int'($urandom_range(i + 1, n - 1));
            else tgt = int'($urandom_range(32, 47));
            mem[i] = {op[3:0], tgt[11:0]};
         end
         mem[n - 1] = 16'hF000;
         for (int i = 32; i < 48; i++) mem[i] = 16'($urandom_range(0, 65535));
         runProgram(-1, "rand");
      end

      // 24/16 instance: wide arithmetic and PC wrap
      mem2[16'h0000] = 24'h100010;   // LDA 0x0010
      mem2[16'h0001] = 24'h400011;   // SUB 0x0011
      mem2[16'h0002] = 24'h60FFFF;   // JMP 0xFFFF
      mem2[16'hFFFF] = 24'h800000;   // INC
      mem2[16'h0010] = 24'hFFFFFF;
      mem2[16'h0011] = 24'hFFFFFF;
      @(negedge clk);
      rst2_n = 1'b1;
      start2 = 1'b1;
      waitFetch2(16'h0001, ok);
      chk("t5_fetch1", ok, 1);
      chk("t5_lda_ac", ac2, 24'hFFFFFF);
      chk("t5_lda_z", z2, 0);
      waitFetch2(16'h0002, ok);
      chk("t5_fetch2", ok, 1);
      chk("t5_sub_ac", ac2, 24'h000000);
      chk("t5_sub_z", z2, 1);
      waitFetch2(16'hFFFF, ok);
      chk("t5_fetch_ffff", ok, 1);
      chk("t5_pc_ffff", pc2, 16'hFFFF);
      waitFetch2(16'h0000, ok);
      chk("t5_fetch_wrap", ok, 1);
      chk("t5_pc_wrap", pc2, 16'h0000);
      chk("t5_inc_ac", ac2, 24'h000001);
      chk("t5_inc_z", z2, 0);
      rst2_n = 1'b0;
      start2 = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
